// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
//
// Purpose: 8-bit UART receiver with a single-entry holding register and a
// ready/valid handshake toward the consumer. The frame is 8N1 by default.
// Defining UART_RX_PARITY_EN adds an even-parity bit between data bit 7 and
// the stop bit.
//
// Parameters:
//   CLKS_PER_BIT - clk cycles per UART bit (even, >= 4)
//
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous, active-low reset
//   RXD        - asynchronous serial input, idles high
//   rx_data    - last accepted byte, held stable while rx_valid is high
//   rx_valid   - rx_data holds a byte the consumer has not taken yet
//   rx_ready   - consumer takes rx_data when rx_valid is high
//   rx_busy    - a frame is in progress (any state other than IDLE)
//   frame_err  - one-cycle pulse when the stop bit is low
//   parity_err - one-cycle pulse on a parity mismatch (0 without parity)
//   overrun    - sticky; a byte was dropped because the holding register
//                was full. Cleared by the next handshake.
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RXD,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t        state, state_d;
  logic          rxd_meta, rxs;
  logic [CW-1:0] baud_cnt, baud_cnt_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shift, shift_d;
  logic          baud_done;
  logic          commit;
  logic          frame_bad;
  logic          handshake;

`ifdef UART_RX_PARITY_EN
  logic par_bit, par_bit_d;
  logic par_fault;
  logic parity_bad;

  // Even parity: the data bits plus the parity bit must hold an even count of ones.
  assign par_fault = ^{shift, par_bit};
`endif

  assign baud_done = (baud_cnt == BIT_LAST);
  assign handshake = rx_valid && rx_ready;

  // Two-flop synchronizer. It resets to the idle level so that a reset does
  // not look like a falling edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_meta <= 1'b1;
      rxs      <= 1'b1;
    end else begin
      rxd_meta <= RXD;
      rxs      <= rxd_meta;
    end
  end

  // State register and frame datapath (baud counter, bit index, shifter).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_idx  <= bit_idx_d;
      shift    <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_bit  <= par_bit_d;
`endif
    end
  end

  // Next-state logic. START waits half a bit so that every later sample
  // lands near the middle of its bit. The stop-bit sample produces the
  // commit/error strobes used by the output register block.
  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt + CW'(1);
    bit_idx_d  = bit_idx;
    shift_d    = shift;
    commit     = 1'b0;
    frame_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d  = par_bit;
    parity_bad = 1'b0;
`endif
    case (state)
      IDLE: begin
        baud_cnt_d = '0;
        bit_idx_d  = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (baud_cnt == HALF_LAST) begin
          baud_cnt_d = '0;
          state_d    = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_cnt_d       = '0;
          shift_d[bit_idx] = rxs;
          bit_idx_d        = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baud_done) begin
          baud_cnt_d = '0;
          par_bit_d  = rxs;
          state_d    = STOP;
        end
      end
`endif
      STOP: begin
        if (baud_done) begin
          baud_cnt_d = '0;
          if (!rxs) begin
            frame_bad = 1'b1;
            state_d   = BREAK;
`ifdef UART_RX_PARITY_EN
          end else if (par_fault) begin
            parity_bad = 1'b1;
            state_d    = IDLE;
`endif
          end else begin
            commit  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      BREAK: begin
        // Stay here while the line is held low so that a long break
        // reports only one frame error.
        baud_cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: begin
        baud_cnt_d = '0;
        state_d    = IDLE;
      end
    endcase
  end

  // Output register block. A handshake in the same cycle as a commit frees
  // the slot, so the new byte is loaded and overrun stays clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_busy   <= (state_d != IDLE);
      frame_err <= frame_bad;
      if (commit && (!rx_valid || rx_ready)) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (handshake) begin
        rx_valid <= 1'b0;
      end
      if (handshake) begin
        overrun <= 1'b0;
      end else if (commit && rx_valid) begin
        overrun <= 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // The parity error pulse lines up with frame_err and the rx_valid rise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= parity_bad;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
//
// Purpose: self-checking bench for uart_rx_ctrl with CLKS_PER_BIT = 16.
// It contains a table of directed frames, hand-written multi-cycle corner
// sequences (glitch, break, overrun, reset mid-frame, parity), and a
// randomized frame stream checked against a queue-based expectation model.
// Parity cases are built only when UART_RX_PARITY_EN is defined.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 10;
`else
  localparam int NBITS = 9;
`endif
  // The synchronizer plus the IDLE detect take 3 edges, then half a start
  // bit, then the data (+parity) and stop bits. The byte commits one edge
  // after the stop sample.
  localparam int LATENCY  = 3 + CPB / 2 + NBITS * CPB;
  localparam int BUSY_LEN = CPB / 2 + NBITS * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       RXD;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_busy;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .RXD        (RXD),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples on the falling edge and keeps only cumulative counts.
  // Test code takes snapshots and compares differences.
  int         valid_cycles = 0;
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  int         valid_rise_cyc = -1;
  int         busy_run = 0;
  int         last_busy_run = 0;
  int         busy_runs = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    prev_valid <= rx_valid;
    if (rx_valid && !prev_valid) valid_rise_cyc <= cyc;
    if (rx_valid) valid_cycles <= valid_cycles + 1;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (parity_err) perr_cnt <= perr_cnt + 1;
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (rx_busy) begin
      busy_run <= busy_run + 1;
    end else if (busy_run != 0) begin
      last_busy_run <= busy_run;
      busy_runs     <= busy_runs + 1;
      busy_run      <= 0;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int t0       = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic driveBit(input logic b);
    RXD = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Sends one frame. It returns on the negedge that ends the stop bit and
  // leaves RXD at the stop-bit level.
  task automatic applyStimulus(input logic [7:0] d, input logic stop_bit, input logic par_ok);
    @(negedge clk);
    t0 = cyc;
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(d[i]);
`ifdef UART_RX_PARITY_EN
    driveBit(par_ok ? ^d : ~^d);
`endif
    driveBit(stop_bit);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         exp_valid;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  int         base_valid, base_ferr, base_perr, base_got, base_runs;
  logic [7:0] exp_q[$];
  int         exp_ferr, exp_perr;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h3C, 1'b0, 0, 1};
    vecs[4] = '{8'h80, 1'b1, 1, 0};
    vecs[5] = '{8'h01, 1'b1, 1, 0};

    RXD      = 1'b1;
    rx_ready = 1'b1;
    reset    = 1'b0;
    #1;
    checkOutput("reset_rx_data", rx_data, 8'h00);
    checkOutput("reset_rx_valid", rx_valid, 1'b0);
    checkOutput("reset_rx_busy", rx_busy, 1'b0);
    checkOutput("reset_frame_err", frame_err, 1'b0);
    checkOutput("reset_parity_err", parity_err, 1'b0);
    checkOutput("reset_overrun", overrun, 1'b0);
    idle(3);
    reset = 1'b1;
    idle(5);

    // Directed frame table; a bad stop bit is followed by 40 more low cycles.
    for (int v = 0; v < 6; v++) begin
      base_valid = valid_cycles;
      base_ferr  = ferr_cnt;
      base_got   = got_q.size();
      applyStimulus(vecs[v].data, vecs[v].stop_bit, 1'b1);
      if (!vecs[v].stop_bit) begin
        idle(40);
        RXD = 1'b1;
      end
      idle(20);
      #1;
      checkOutput($sformatf("vec%0d_valid_cycles", v), valid_cycles - base_valid, vecs[v].exp_valid);
      checkOutput($sformatf("vec%0d_frame_err", v), ferr_cnt - base_ferr, vecs[v].exp_ferr);
      checkOutput($sformatf("vec%0d_busy_idle", v), rx_busy, 1'b0);
      if (vecs[v].exp_valid != 0) begin
        checkOutput($sformatf("vec%0d_handshakes", v), got_q.size() - base_got, 1);
        checkOutput($sformatf("vec%0d_data", v), got_q[got_q.size()-1], vecs[v].data);
        checkOutput($sformatf("vec%0d_latency", v), valid_rise_cyc - t0, LATENCY);
        checkOutput($sformatf("vec%0d_busy_len_ok", v),
                    (last_busy_run >= BUSY_LEN - 2 && last_busy_run <= BUSY_LEN + 2), 1'b1);
      end
    end

    // Glitch: three low cycles are too short to survive the mid-start check.
    base_valid = valid_cycles;
    base_ferr  = ferr_cnt;
    base_runs  = busy_runs;
    @(negedge clk);
    RXD = 1'b0;
    idle(3);
    RXD = 1'b1;
    idle(30);
    #1;
    checkOutput("glitch_valid", valid_cycles - base_valid, 0);
    checkOutput("glitch_frame_err", ferr_cnt - base_ferr, 0);
    checkOutput("glitch_busy_pulses", busy_runs - base_runs, 1);
    checkOutput("glitch_busy_short", (last_busy_run >= 1 && last_busy_run <= 8), 1'b1);

    // Overrun: the second byte is dropped while the first is still held.
    rx_ready   = 1'b0;
    base_got   = got_q.size();
    applyStimulus(8'h11, 1'b1, 1'b1);
    idle(5);
    applyStimulus(8'h22, 1'b1, 1'b1);
    idle(20);
    #1;
    checkOutput("ovr_rx_data", rx_data, 8'h11);
    checkOutput("ovr_rx_valid", rx_valid, 1'b1);
    checkOutput("ovr_overrun", overrun, 1'b1);
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("ovr_hs_valid", rx_valid, 1'b0);
    checkOutput("ovr_hs_overrun", overrun, 1'b0);
    checkOutput("ovr_handshakes", got_q.size() - base_got, 1);
    checkOutput("ovr_hs_data", got_q[got_q.size()-1], 8'h11);

    // Reset during bit 4, with a byte still held so rx_data is non-zero.
    rx_ready = 1'b0;
    applyStimulus(8'h33, 1'b1, 1'b1);
    idle(5);
    @(negedge clk);
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(((8'h5A >> i) & 8'h01) != 0);
    RXD = 1'b0;
    idle(8);
    reset = 1'b0;
    #1;
    checkOutput("midrst_rx_data", rx_data, 8'h00);
    checkOutput("midrst_rx_valid", rx_valid, 1'b0);
    checkOutput("midrst_rx_busy", rx_busy, 1'b0);
    checkOutput("midrst_frame_err", frame_err, 1'b0);
    checkOutput("midrst_overrun", overrun, 1'b0);
    idle(2);
    RXD = 1'b1;
    idle(2);
    reset    = 1'b1;
    rx_ready = 1'b1;
    idle(10);
    base_ferr = ferr_cnt;
    base_got  = got_q.size();
    applyStimulus(8'h5A, 1'b1, 1'b1);
    idle(20);
    #1;
    checkOutput("postrst_handshakes", got_q.size() - base_got, 1);
    checkOutput("postrst_data", got_q[got_q.size()-1], 8'h5A);
    checkOutput("postrst_frame_err", ferr_cnt - base_ferr, 0);

`ifdef UART_RX_PARITY_EN
    base_valid = valid_cycles;
    base_perr  = perr_cnt;
    applyStimulus(8'h07, 1'b1, 1'b0);
    idle(20);
    #1;
    checkOutput("par_bad_perr", perr_cnt - base_perr, 1);
    checkOutput("par_bad_valid", valid_cycles - base_valid, 0);
    base_got = got_q.size();
    applyStimulus(8'h07, 1'b1, 1'b1);
    idle(20);
    #1;
    checkOutput("par_good_hs", got_q.size() - base_got, 1);
    checkOutput("par_good_data", rx_data, 8'h07);
`endif

    // Randomized stream: the model keeps the bytes that must arrive in order
    // and counts the error pulses each frame must produce.
    exp_q.delete();
    exp_ferr  = 0;
    exp_perr  = 0;
    base_ferr = ferr_cnt;
    base_perr = perr_cnt;
    base_got  = got_q.size();
    for (int f = 0; f < 20; f++) begin
      logic [7:0] d;
      logic       stop_ok, par_ok;
      d       = 8'($urandom);
      stop_ok = ($urandom_range(0, 9) != 0);
`ifdef UART_RX_PARITY_EN
      par_ok  = ($urandom_range(0, 4) != 0);
`else
      par_ok  = 1'b1;
`endif
      if (!stop_ok) exp_ferr++;
      else if (!par_ok) exp_perr++;
      else exp_q.push_back(d);
      applyStimulus(d, stop_ok, par_ok);
      if (!stop_ok) begin
        idle($urandom_range(0, 20));
        RXD = 1'b1;
        idle($urandom_range(4, 30));
      end else begin
        idle($urandom_range(0, 30));
      end
    end
    idle(20);
    #1;
    checkOutput("rand_count", got_q.size() - base_got, exp_q.size());
    checkOutput("rand_frame_err", ferr_cnt - base_ferr, exp_ferr);
    checkOutput("rand_parity_err", perr_cnt - base_perr, exp_perr);
    for (int i = 0; i < exp_q.size() && base_got + i < got_q.size(); i++)
      checkOutput($sformatf("rand_data%0d", i), got_q[base_got + i], exp_q[i]);
    checkOutput("rand_overrun", overrun, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
